call_stack: RTL and testbench

- Return-address stack for the jrb8 CPU; the counterpart of the jump unit.
- The jump unit consumes a target address and drives the program counter. This block captures the current PC on CALL and drives it back onto the PC input on RET.
- Sits beside the jump unit on the PC mux. It shares the same `pcoe`/`pcout` convention: `pcout` is zero whenever `pcoe` is low.
- Provides a two-beat 16-bit databus path to spill the top entry to memory, and a two-beat restore path to reload it.

---
 rtl/call_stack.sv | 185 ++++++++++++++++++
 tb/tb_call_stack.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// call_stack -- return-address stack for the jrb8 CPU.
//
// CALL captures a caller-computed return address. RET drives the top entry
// back onto the PC mux for one cycle. The top entry can also be spilled to
// memory as two 16-bit beats, and a word can be restored through two
// databus writes.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   call, ret, pcin     push pcin / pop top onto pcout (both = tail call)
//   pcoe, pcout         PC load enable and popped address (0 when pcoe=0)
//   dump, dready        start spill of top entry / memory accepts beat
//   dvalid, dout        spill beat valid / spill data (low half, then high)
//   databus             restore data
//   rs_lo_we, rs_hi_we  latch low half / push {databus, latched low half}
//   busy                FSM not idle
//   sp                  entry count 0..DEPTH
//   overflow, underflow sticky error flags, cleared only by reset
module call_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     call,
  input  logic                     ret,
  input  logic [AW-1:0]            pcin,
  output logic                     pcoe,
  output logic [AW-1:0]            pcout,
  input  logic                     dump,
  input  logic                     dready,
  output logic                     dvalid,
  output logic [15:0]              dout,
  input  logic [15:0]              databus,
  input  logic                     rs_lo_we,
  input  logic                     rs_hi_we,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  typedef enum logic [1:0] {IDLE, RET_OUT, DUMP_LO, DUMP_HI} state_t;

  state_t          state_reg;
  logic [SW-1:0]   sp_reg;
  logic            overflow_reg;
  logic            underflow_reg;
  logic [15:0]     lo_reg;

  // Entry storage (no reset) with a registered read of the top entry.
  logic [AW-1:0]   entry_mem [DEPTH];
  logic [AW-1:0]   top_reg;

  logic            idle;
  logic            empty;
  logic            full;
  logic [IW-1:0]   top_idx;
  logic [AW-1:0]   restore_word;
  logic            do_call;
  logic            do_ret;
  logic            do_dump;
  logic            do_rs;
  logic            wr_en;
  logic [IW-1:0]   wr_addr;
  logic [AW-1:0]   wr_data;
  logic            rd_en;
  logic [15:0]     hi_word;

  assign idle  = (state_reg == IDLE);
  assign empty = (sp_reg == '0);
  assign full  = (sp_reg == SW'(DEPTH));
  // When full, the low index bits are zero, so this still wraps to DEPTH-1.
  assign top_idx      = sp_reg[IW-1:0] - IW'(1);
  assign restore_word = {databus[AW-17:0], lo_reg};

  always_comb begin
    // IDLE priority: call/ret, then dump, then rs_hi_we.
    do_call = idle & call;
    do_ret  = idle & ret;
    do_dump = idle & ~call & ~ret & dump;
    do_rs   = idle & ~call & ~ret & ~dump & rs_hi_we;
    wr_en   = 1'b0;
    wr_addr = sp_reg[IW-1:0];
    wr_data = do_rs ? restore_word : pcin;
    rd_en   = 1'b0;
    if ((do_call && !do_ret) || do_rs) begin
      wr_en = ~full;
    end else if (do_call && do_ret) begin
      // Tail call overwrites the top in place; on an empty stack it is a push.
      wr_en = 1'b1;
      if (!empty) begin
        wr_addr = top_idx;
      end
    end
    if ((do_ret || do_dump) && !empty) begin
      rd_en = 1'b1;
    end
  end

  // Read-before-write on the same index gives the tail call its old top.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entry_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      top_reg <= entry_mem[top_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      lo_reg        <= '0;
    end else begin
      if (rs_lo_we) begin
        lo_reg <= databus;
      end
      case (state_reg)
        IDLE: begin
          if (call || ret) begin
            if (call && !ret) begin
              if (full) overflow_reg <= 1'b1;
              else      sp_reg <= sp_reg + SW'(1);
            end else if (ret && !call) begin
              if (empty) begin
                underflow_reg <= 1'b1;
              end else begin
                sp_reg    <= sp_reg - SW'(1);
                state_reg <= RET_OUT;
              end
            end else begin
              if (empty) begin
                sp_reg        <= sp_reg + SW'(1);
                underflow_reg <= 1'b1;
              end else begin
                state_reg <= RET_OUT;
              end
            end
          end else if (dump) begin
            if (empty) underflow_reg <= 1'b1;
            else       state_reg <= DUMP_LO;
          end else if (rs_hi_we) begin
            if (full) overflow_reg <= 1'b1;
            else      sp_reg <= sp_reg + SW'(1);
          end
        end
        RET_OUT: state_reg <= IDLE;
        DUMP_LO: begin
          if (dready) state_reg <= DUMP_HI;
        end
        DUMP_HI: begin
          if (dready) begin
            sp_reg    <= sp_reg - SW'(1);
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and registers only.
  always_comb begin
    hi_word = '0;
    hi_word[AW-17:0] = top_reg[AW-1:16];
  end

  assign pcoe      = (state_reg == RET_OUT);
  assign pcout     = pcoe ? top_reg : '0;
  assign dvalid    = (state_reg == DUMP_LO) || (state_reg == DUMP_HI);
  assign dout      = (state_reg == DUMP_LO) ? top_reg[15:0] :
                     (state_reg == DUMP_HI) ? hi_word : 16'h0000;
  assign busy      = ~idle;
  assign sp        = sp_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_call_stack.sv
module tb_call_stack;
  localparam int DEPTH = 16;
  localparam int AW    = 23;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          call = 1'b0, ret = 1'b0, dump = 1'b0, dready = 1'b0;
  logic          rs_lo_we = 1'b0, rs_hi_we = 1'b0;
  logic [AW-1:0] pcin = '0;
  logic [15:0]   databus = '0;
  logic          pcoe, dvalid, busy, overflow, underflow;
  logic [AW-1:0] pcout;
  logic [15:0]   dout;
  logic [4:0]    sp;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] model[$];    // reference stack contents
  logic [AW-1:0] exp_pc[$];   // scoreboard: expected RET outputs
  logic [15:0]   exp_beat[$]; // scoreboard: expected spill beats

  call_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .call(call), .ret(ret), .pcin(pcin),
    .pcoe(pcoe), .pcout(pcout), .dump(dump), .dready(dready),
    .dvalid(dvalid), .dout(dout), .databus(databus), .rs_lo_we(rs_lo_we),
    .rs_hi_we(rs_hi_we), .busy(busy), .sp(sp), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; call = 0; ret = 0; dump = 0; dready = 0;
    rs_lo_we = 0; rs_hi_we = 0; pcin = '0; databus = '0;
    tick();
    rst_n = 1'b1;
    model.delete(); exp_pc.delete(); exp_beat.delete();
  endtask

  // Plain push; model applies the full rule.
  task automatic push(input logic [AW-1:0] pc);
    call = 1'b1; pcin = pc;
    if (model.size() < DEPTH) model.push_back(pc);
    tick();
    call = 1'b0;
  endtask

  // Plain pop; the expected output is queued when the stimulus is driven.
  task automatic pop();
    ret = 1'b1;
    if (model.size() > 0) exp_pc.push_back(model.pop_back());
    tick();
    ret = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW-1:0] e;
    apply_reset();
    checks++;
    if ({pcoe, pcout, dvalid, dout, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs got pcoe=%0b pcout=%0h dvalid=%0b dout=%0h busy=%0b required all 0", pcoe, pcout, dvalid, dout, busy);
    end
    checks++;
    if ({sp, overflow, underflow} !== '0) begin
      errors++; $display("FAIL reset_state got sp=%0d ovf=%0b unf=%0b required 0", sp, overflow, underflow);
    end
    $display("reset: sp=%0d busy=%0b", sp, busy);
  endtask

  task automatic test_push_pop();
    logic [AW-1:0] e;
    apply_reset();
    push(23'h000123);
    push(23'h7ABCDE);
    checks++;
    if (sp !== 5'd2) begin errors++; $display("FAIL pp_sp got %0d required 2", sp); end
    pop();
    e = exp_pc.pop_front();
    checks++;
    if (pcoe !== 1'b1 || pcout !== e) begin
      errors++; $display("FAIL pp_ret got pcoe=%0b pcout=%0h required 1/%0h", pcoe, pcout, e);
    end
    checks++;
    if (sp !== 5'd1) begin errors++; $display("FAIL pp_sp_after got %0d required 1", sp); end
    $display("ret: pcout=%06h", pcout);
    tick();
    checks++;
    if (pcoe !== 1'b0 || pcout !== '0) begin
      errors++; $display("FAIL pp_idle got pcoe=%0b pcout=%0h required 0/0", pcoe, pcout);
    end
    pop();
    e = exp_pc.pop_front();
    checks++;
    if (pcout !== e) begin errors++; $display("FAIL pp_ret2 got %0h required %0h", pcout, e); end
    $display("ret: pcout=%06h", pcout);
    tick();
  endtask

  task automatic test_full();
    logic [AW-1:0] e;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) push(AW'($urandom_range(1, 23'h7FFFFF)));
    push(23'h000055); // ignored by the model: stack is full
    checks++;
    if (sp !== 5'd16 || overflow !== 1'b1) begin
      errors++; $display("FAIL full_ovf got sp=%0d ovf=%0b required 16/1", sp, overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      e = exp_pc.pop_front();
      checks++;
      if (pcoe !== 1'b1 || pcout !== e) begin
        errors++; $display("FAIL full_lifo[%0d] got pcoe=%0b pcout=%0h required 1/%0h", i, pcoe, pcout, e);
      end
      $display("ret %0d: pcout=%06h", i, pcout);
      tick();
    end
    pop(); // empty: nothing queued
    checks++;
    if (underflow !== 1'b1 || pcoe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL full_unf got unf=%0b pcoe=%0b busy=%0b required 1/0/0", underflow, pcoe, busy);
    end
    tick();
    checks++;
    if (pcoe !== 1'b0 || exp_pc.size() != 0) begin
      errors++; $display("FAIL full_unf_pcoe got %0b required 0", pcoe);
    end
  endtask

  task automatic test_tail();
    logic [AW-1:0] e;
    apply_reset();
    push(23'h10);
    push(23'h20);
    call = 1'b1; ret = 1'b1; pcin = 23'h30;
    exp_pc.push_back(model.pop_back());
    model.push_back(23'h30);
    tick();
    call = 1'b0; ret = 1'b0;
    e = exp_pc.pop_front();
    checks++;
    if (pcoe !== 1'b1 || pcout !== e || sp !== 5'd2) begin
      errors++; $display("FAIL tail_ret got pcoe=%0b pcout=%0h sp=%0d required 1/%0h/2", pcoe, pcout, sp, e);
    end
    $display("tail: pcout=%06h sp=%0d", pcout, sp);
    tick();
    pop();
    e = exp_pc.pop_front();
    checks++;
    if (pcout !== e) begin errors++; $display("FAIL tail_next got %0h required %0h", pcout, e); end
    tick();
    // Tail call on an empty stack: plain push plus underflow.
    apply_reset();
    call = 1'b1; ret = 1'b1; pcin = 23'h44;
    model.push_back(23'h44);
    tick();
    call = 1'b0; ret = 1'b0;
    checks++;
    if (pcoe !== 1'b0 || sp !== 5'd1 || underflow !== 1'b1) begin
      errors++; $display("FAIL tail_empty got pcoe=%0b sp=%0d unf=%0b required 0/1/1", pcoe, sp, underflow);
    end
    pop();
    e = exp_pc.pop_front();
    checks++;
    if (pcout !== e) begin errors++; $display("FAIL tail_empty_ret got %0h required %0h", pcout, e); end
    tick();
  endtask

  task automatic test_spill();
    logic [AW-1:0] w;
    logic [15:0]   b;
    apply_reset();
    w = 23'h6F1234;
    push(w);
    dump = 1'b1;
    exp_beat.push_back(w[15:0]);
    exp_beat.push_back({9'b0, w[22:16]});
    tick();
    dump = 1'b0;
    dready = 1'b0; call = 1'b1; pcin = 23'h999;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dvalid !== 1'b1 || dout !== exp_beat[0] || busy !== 1'b1) begin
        errors++; $display("FAIL spill_hold[%0d] got dvalid=%0b dout=%0h busy=%0b required 1/%0h/1", i, dvalid, dout, busy, exp_beat[0]);
      end
      tick();
    end
    dready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b = exp_beat.pop_front();
      checks++;
      if (dvalid !== 1'b1 || dout !== b) begin
        errors++; $display("FAIL spill_beat[%0d] got dvalid=%0b dout=%0h required 1/%0h", i, dvalid, dout, b);
      end
      $display("spill beat %0d: dout=%04h", i, dout);
      tick();
    end
    call = 1'b0; dready = 1'b0;
    model.pop_back();
    checks++;
    if (sp !== 5'd0 || busy !== 1'b0 || dvalid !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL spill_done got sp=%0d busy=%0b dvalid=%0b unf=%0b required 0/0/0/0", sp, busy, dvalid, underflow);
    end
    // Dump on an empty stack only raises underflow.
    dump = 1'b1;
    tick();
    dump = 1'b0;
    checks++;
    if (underflow !== 1'b1 || busy !== 1'b0 || dvalid !== 1'b0) begin
      errors++; $display("FAIL dump_empty got unf=%0b busy=%0b dvalid=%0b required 1/0/0", underflow, busy, dvalid);
    end
  endtask

  task automatic test_restore();
    logic [AW-1:0] e;
    apply_reset();
    databus = 16'hBEEF; rs_lo_we = 1'b1;
    tick();
    rs_lo_we = 1'b0; databus = 16'h0041; rs_hi_we = 1'b1;
    model.push_back({7'h41, 16'hBEEF});
    tick();
    rs_hi_we = 1'b0;
    checks++;
    if (sp !== 5'd1) begin errors++; $display("FAIL restore_sp got %0d required 1", sp); end
    pop();
    e = exp_pc.pop_front();
    checks++;
    if (pcout !== e) begin errors++; $display("FAIL restore_ret got %0h required %0h", pcout, e); end
    $display("restore: pcout=%06h", pcout);
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    // call outranks rs_hi_we in the same cycle: exactly one push.
    call = 1'b1; pcin = 23'h1; rs_hi_we = 1'b1;
    tick();
    call = 1'b0; rs_hi_we = 1'b0;
    checks++;
    if (sp !== 5'd1 || overflow !== 1'b0) begin
      errors++; $display("FAIL prio_call got sp=%0d ovf=%0b required 1/0", sp, overflow);
    end
  endtask

  task automatic test_reset_mid_spill();
    apply_reset();
    push(23'h6F1234);
    dump = 1'b1;
    tick();
    dump = 1'b0; dready = 1'b1;
    tick();
    dready = 1'b0;
    checks++;
    if (dout !== 16'h006F) begin errors++; $display("FAIL mid_hi got %0h required 006f", dout); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (dvalid !== 1'b0 || sp !== 5'd0 || busy !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset got dvalid=%0b sp=%0d busy=%0b ovf=%0b unf=%0b required 0", dvalid, sp, busy, overflow, underflow);
    end
    dready = 1'b1;
    tick();
    tick();
    dready = 1'b0;
    checks++;
    if (dvalid !== 1'b0 || dout !== 16'h0) begin
      errors++; $display("FAIL mid_no_repeat got dvalid=%0b dout=%0h required 0/0", dvalid, dout);
    end
    $display("reset mid-spill: dvalid=%0b sp=%0d", dvalid, sp);
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_tail();
    test_spill();
    test_restore();
    test_back_to_back();
    test_reset_mid_spill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
